// File: rtl/sobol_bitgen.sv
// Binary-to-stochastic bitstream generator driven by a first-dimension Sobol
// (van der Corput) sequence. One accepted value yields 2^BITWIDTH stream bits
// whose count of ones equals the value.
module sobol_bitgen #(
  parameter int unsigned BITWIDTH = 4
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iValid,
  input  logic [BITWIDTH-1:0] iData,
  output logic                oReady,
  input  logic                iHold,
  output logic                oBit,
  output logic                oBitVld,
  output logic                oLast,
  output logic [BITWIDTH-1:0] oOnes
);

  localparam int unsigned W = BITWIDTH;
  localparam logic [W-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state, stateNext;
  logic [W-1:0] n, nNext;
  logic [W-1:0] x, xNext;
  logic [W-1:0] val, valNext;
  logic [W-1:0] ones, onesNext;
  logic [W-1:0] flipMask;
  logic         found;

  // Sobol direction mask: one bit mirrored from the least-significant zero of n.
  always_comb begin
    flipMask = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && !n[i]) begin
        flipMask[W-1-i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  // Next-state, datapath updates and stream outputs.
  always_comb begin
    stateNext = state;
    nNext     = n;
    xNext     = x;
    valNext   = val;
    onesNext  = ones;
    oReady    = 1'b0;
    oBitVld   = 1'b0;
    oBit      = 1'b0;
    oLast     = 1'b0;
    unique case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          valNext   = iData;
          nNext     = '0;
          xNext     = '0;
          onesNext  = '0;
          stateNext = RUN;
        end
      end
      RUN: begin
        oBitVld = !iHold;
        oBit    = oBitVld & (x < val);
        oLast   = oBitVld & (n == LAST_IDX);
        if (oBitVld) begin
          onesNext = ones + W'(oBit);
          if (oLast) begin
            stateNext = IDLE;
          end else begin
            nNext = n + W'(1);
            xNext = x ^ flipMask;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
      n     <= '0;
      x     <= '0;
      val   <= '0;
      ones  <= '0;
    end else begin
      state <= stateNext;
      n     <= nNext;
      x     <= xNext;
      val   <= valNext;
      ones  <= onesNext;
    end
  end

  assign oOnes = ones;

endmodule

// File: tb/tb_sobol_bitgen.sv
// Self-checking bench for sobol_bitgen (BITWIDTH=4) using a scoreboard of
// expected stream bits built from a Gray-code bit-reversal reference.
module tb_sobol_bitgen;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic       iValid;
  logic [3:0] iData;
  logic       oReady;
  logic       iHold;
  logic       oBit;
  logic       oBitVld;
  logic       oLast;
  logic [3:0] oOnes;

  int tests    = 0;
  int failures = 0;

  logic       expBits[$];
  logic [3:0] expOnes[$];

  sobol_bitgen #(.BITWIDTH(4)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iValid (iValid),
    .iData  (iData),
    .oReady (oReady),
    .iHold  (iHold),
    .oBit   (oBit),
    .oBitVld(oBitVld),
    .oLast  (oLast),
    .oOnes  (oOnes)
  );

  always #5 iClk = ~iClk;

  // Van der Corput point n = bit reversal of the Gray code of n.
  function automatic logic [3:0] refX(input int n);
    logic [3:0] g;
    g = 4'(n ^ (n >> 1));
    return {g[0], g[1], g[2], g[3]};
  endfunction

  // Scoreboard push: all expected bits of a stream plus its final ones count.
  function automatic void pushStream(input logic [3:0] v);
    int cnt;
    logic b;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      b = (refX(i) < v);
      expBits.push_back(b);
      cnt += int'(b);
    end
    expOnes.push_back(4'(cnt));
  endfunction

  task automatic test_reset();
    iRstN = 1'b0; iValid = 1'b0; iData = 4'd0; iHold = 1'b0;
    repeat (3) @(negedge iClk);
    #1;
    tests++;
    if ({oReady, oBitVld, oBit, oLast, oOnes} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset: ready/vld/bit/last/ones=%b required 10000000",
               {oReady, oBitVld, oBit, oLast, oOnes});
    end
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  task automatic test_values();
    logic [3:0] vals[3];
    logic       eb;
    vals[0] = 4'd0; vals[1] = 4'd15; vals[2] = 4'd5;
    for (int t = 0; t < 3; t++) begin
      @(negedge iClk);
      iValid = 1'b1; iData = vals[t];
      #1;
      tests++;
      if (oReady !== 1'b1) begin
        failures++; $display("FAIL val%0d ready_before: got %b need 1", vals[t], oReady);
      end
      pushStream(vals[t]);
      @(negedge iClk);
      iValid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        #1;
        eb = expBits.pop_front();
        tests++;
        if (oBitVld !== 1'b1 || oBit !== eb || oLast !== (i == 15) || oReady !== 1'b0) begin
          failures++;
          $display("FAIL val%0d bit%0d: vld=%b bit=%b last=%b ready=%b need vld=1 bit=%b last=%b ready=0",
                   vals[t], i, oBitVld, oBit, oLast, oReady, eb, (i == 15));
        end
        @(negedge iClk);
      end
      #1;
      tests++;
      if (oReady !== 1'b1 || oBitVld !== 1'b0 || oOnes !== expOnes[0]) begin
        failures++;
        $display("FAIL val%0d end: ready=%b vld=%b ones=%0d need ready=1 vld=0 ones=%0d",
                 vals[t], oReady, oBitVld, oOnes, expOnes[0]);
      end
      void'(expOnes.pop_front());
    end
  endtask

  task automatic test_hold();
    int   bitIdx, hold4, hold15, lastCyc, stalls;
    logic h, eb;
    bitIdx = 0; hold4 = 0; hold15 = 0; lastCyc = 0; stalls = 0;
    @(negedge iClk);
    iValid = 1'b1; iData = 4'd9;
    pushStream(4'd9);
    @(negedge iClk);
    iValid = 1'b0;
    for (int cyc = 1; cyc <= 40 && bitIdx < 16; cyc++) begin
      h = (bitIdx == 4 && hold4 < 3) || (bitIdx == 15 && hold15 < 1);
      iHold = h;
      #1;
      tests++;
      if (oBitVld !== !h) begin
        failures++; $display("FAIL hold vld cyc%0d: got %b need %b", cyc, oBitVld, !h);
      end
      if (h) begin
        stalls++;
        if (bitIdx == 4) hold4++; else hold15++;
        tests++;
        if (oLast !== 1'b0) begin
          failures++; $display("FAIL hold last_during_stall cyc%0d: got %b need 0", cyc, oLast);
        end
      end else begin
        eb = expBits.pop_front();
        tests++;
        if (oBit !== eb || oLast !== (bitIdx == 15)) begin
          failures++;
          $display("FAIL hold bit%0d: bit=%b last=%b need bit=%b last=%b",
                   bitIdx, oBit, oLast, eb, (bitIdx == 15));
        end
        if (oLast === 1'b1) lastCyc = cyc;
        bitIdx++;
      end
      @(negedge iClk);
    end
    iHold = 1'b0;
    tests++;
    if (bitIdx != 16 || lastCyc != 16 + stalls) begin
      failures++;
      $display("FAIL hold timing: bits=%0d last_cycle=%0d need bits=16 last_cycle=%0d",
               bitIdx, lastCyc, 16 + stalls);
    end
    #1;
    tests++;
    if (oReady !== 1'b1 || oOnes !== expOnes[0]) begin
      failures++;
      $display("FAIL hold end: ready=%b ones=%0d need ready=1 ones=%0d", oReady, oOnes, expOnes[0]);
    end
    void'(expOnes.pop_front());
  endtask

  task automatic test_ignore_reset();
    logic eb;
    @(negedge iClk);
    iValid = 1'b1; iData = 4'd12;
    pushStream(4'd12);
    @(negedge iClk);
    iData = 4'd2;
    for (int i = 0; i < 7; i++) begin
      #1;
      eb = expBits.pop_front();
      tests++;
      if (oBitVld !== 1'b1 || oBit !== eb || oReady !== 1'b0) begin
        failures++;
        $display("FAIL ignore bit%0d: vld=%b bit=%b ready=%b need vld=1 bit=%b ready=0",
                 i, oBitVld, oBit, oReady, eb);
      end
      @(negedge iClk);
    end
    iRstN = 1'b0; iValid = 1'b0;
    #1;
    tests++;
    if ({oReady, oBitVld, oBit, oLast, oOnes} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL midreset: ready/vld/bit/last/ones=%b required 10000000",
               {oReady, oBitVld, oBit, oLast, oOnes});
    end
    expBits.delete();
    expOnes.delete();
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    iValid = 1'b1; iData = 4'd3;
    pushStream(4'd3);
    @(negedge iClk);
    iValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      eb = expBits.pop_front();
      tests++;
      if (oBitVld !== 1'b1 || oBit !== eb || oLast !== (i == 15)) begin
        failures++;
        $display("FAIL fresh3 bit%0d: vld=%b bit=%b last=%b need vld=1 bit=%b last=%b",
                 i, oBitVld, oBit, oLast, eb, (i == 15));
      end
      @(negedge iClk);
    end
    #1;
    tests++;
    if (oReady !== 1'b1 || oOnes !== expOnes[0]) begin
      failures++;
      $display("FAIL fresh3 end: ready=%b ones=%0d need ready=1 ones=%0d", oReady, oOnes, expOnes[0]);
    end
    void'(expOnes.pop_front());
  endtask

  task automatic test_back_to_back();
    int   started, accK, bitIdx;
    logic eb;
    logic [3:0] eo;
    started = 0; accK = 0; bitIdx = 0;
    @(negedge iClk);
    iValid = 1'b1; iData = 4'd0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (oReady === 1'b1) begin
        if (started > 0) begin
          eo = expOnes.pop_front();
          tests++;
          if (oOnes !== eo || k - accK != 17 || bitIdx != 16) begin
            failures++;
            $display("FAIL b2b stream%0d: ones=%0d spacing=%0d bits=%0d need ones=%0d spacing=17 bits=16",
                     started - 1, oOnes, k - accK, bitIdx, eo);
          end
        end
        if (started == 16) begin
          iValid = 1'b0;
          break;
        end
        pushStream(iData);
        accK = k; bitIdx = 0;
        started++;
      end else if (oBitVld === 1'b1) begin
        eb = expBits.pop_front();
        tests++;
        if (oBit !== eb || oLast !== (bitIdx == 15)) begin
          failures++;
          $display("FAIL b2b stream%0d bit%0d: bit=%b last=%b need bit=%b last=%b",
                   started - 1, bitIdx, oBit, oLast, eb, (bitIdx == 15));
        end
        if (oLast === 1'b1) iData = 4'(started);
        bitIdx++;
      end
      @(negedge iClk);
    end
    iValid = 1'b0;
    tests++;
    if (started != 16 || expOnes.size() != 0) begin
      failures++;
      $display("FAIL b2b count: streams=%0d pending=%0d need streams=16 pending=0",
               started, expOnes.size());
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_hold();
    test_ignore_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
